// File: rtl/cordic_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cordic_arbiter
// Description : Round-robin arbiter/sequencer sharing one iterative CORDIC
//               core between two angle requesters, with a done watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_arbiter #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] X_INIT  = WIDTH'(8'h4B),
    parameter int               TIMEOUT = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    input  logic [WIDTH-1:0] req0_z_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [WIDTH-1:0] req1_z_i,
    output logic             req1_ready_o,
    output logic             cordic_strobe_o,
    output logic [WIDTH-1:0] cordic_x_o,
    output logic [WIDTH-1:0] cordic_y_o,
    output logic [WIDTH-1:0] cordic_z_o,
    input  logic [WIDTH-1:0] cordic_x_i,
    input  logic [WIDTH-1:0] cordic_y_i,
    input  logic             cordic_done_i,
    output logic             rsp_valid_o,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_x_o,
    output logic [WIDTH-1:0] rsp_y_o,
    output logic             rsp_timeout_o,
    output logic             busy_o
);

    localparam int               c_CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_ptr;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_z;
    logic               r_id;
    logic [WIDTH-1:0]   r_rsp_x;
    logic [WIDTH-1:0]   r_rsp_y;
    logic               r_rsp_timeout;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_hs;
    logic               w_last;

    // A lone valid requester always wins; the pointer only breaks ties.
    assign w_grant0 = req0_valid_i & (~req1_valid_i | ~r_ptr);
    assign w_grant1 = req1_valid_i & (~req0_valid_i | r_ptr);

    assign req0_ready_o = (r_state == c_IDLE) & w_grant0;
    assign req1_ready_o = (r_state == c_IDLE) & w_grant1;
    assign w_hs         = req0_ready_o | req1_ready_o;
    assign w_last       = (r_cnt == c_CNT_MAX);

    assign cordic_strobe_o = (r_state == c_ISSUE);
    assign cordic_x_o      = X_INIT;
    assign cordic_y_o      = '0;
    assign cordic_z_o      = r_z;
    assign rsp_valid_o     = (r_state == c_RESP);
    assign rsp_id_o        = r_id;
    assign rsp_x_o         = r_rsp_x;
    assign rsp_y_o         = r_rsp_y;
    assign rsp_timeout_o   = r_rsp_timeout;
    assign busy_o          = (r_state != c_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_hs) w_state_nxt = c_ISSUE;
            c_ISSUE: w_state_nxt = c_WAIT;
            c_WAIT:  if (cordic_done_i || w_last) w_state_nxt = c_RESP;
            c_RESP:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state       <= c_IDLE;
            r_ptr         <= 1'b0;
            r_cnt         <= '0;
            r_z           <= '0;
            r_id          <= 1'b0;
            r_rsp_x       <= '0;
            r_rsp_y       <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_IDLE: begin
                    if (w_hs) begin
                        r_z  <= w_grant1 ? req1_z_i : req0_z_i;
                        r_id <= w_grant1;
                    end
                end
                c_ISSUE: r_cnt <= '0;
                c_WAIT: begin
                    // Done takes precedence over an expiring watchdog.
                    if (cordic_done_i) begin
                        r_rsp_x       <= cordic_x_i;
                        r_rsp_y       <= cordic_y_i;
                        r_rsp_timeout <= 1'b0;
                    end else if (w_last) begin
                        r_rsp_x       <= '0;
                        r_rsp_y       <= '0;
                        r_rsp_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                c_RESP:  r_ptr <= ~r_id;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
